// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator bank: sweep FSM encoding and
// the guard-bit rule used to detect signed overflow of a column sum.
package accum_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // One guard bit above ACC_WIDTH is enough to hold any ACC + sign-extended DATA sum.
    localparam int unsigned SUM_GUARD_BITS = 1;

    function automatic logic add_overflow(input logic [1:0] top2);
        return top2[1] ^ top2[0];
    endfunction

endpackage

// File: rtl/accum_bank_if.sv
// Request/response bundle of the accumulator bank: clear/busy, write pipeline
// inputs, read port and sticky overflow flags.
interface accum_bank_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned NUM_COLS   = 16,
    parameter int unsigned AW         = 10
);
    logic                           clear;
    logic                           busy;
    logic                           wr_en;
    logic                           wr_mode;
    logic [AW-1:0]                  wr_addr;
    logic [NUM_COLS*DATA_WIDTH-1:0] wr_data;
    logic                           rd_en;
    logic [AW-1:0]                  rd_addr;
    logic                           rd_valid;
    logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data;
    logic [NUM_COLS-1:0]            ovf;

    modport master (
        output clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_valid, rd_data, ovf
    );

    modport slave (
        input  clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_valid, rd_data, ovf
    );
endinterface

// File: rtl/accum_lane.sv
// One accumulator column: row storage, stage-1/stage-2 data registers,
// sign-extend + saturating/wrapping add, read register and sticky overflow.
module accum_lane
    import accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = 10,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s1_load,
    input  logic [DATA_WIDTH-1:0] wr_data_col,
    input  logic [AW-1:0]         s1_addr,
    input  logic                  s2_load,
    input  logic                  fwd_hit,
    input  logic                  s2_mode,
    input  logic                  s2_commit,
    input  logic [AW-1:0]         s2_addr,
    input  logic                  sweep_we,
    input  logic [AW-1:0]         sweep_row,
    input  logic                  rd_accept,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  ovf_clr,
    output logic [ACC_WIDTH-1:0]  rd_data_col,
    output logic                  ovf
);
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + SUM_GUARD_BITS;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0]         mem_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic signed [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic signed [ACC_WIDTH-1:0]  s2_old_q, s2_old_d;
    logic [ACC_WIDTH-1:0]         rd_data_q, rd_data_d;
    logic                         ovf_q, ovf_d;

    logic signed [ACC_WIDTH-1:0]  data_ext;
    logic signed [SUM_WIDTH-1:0]  sum_wide;
    logic                         sum_ovf;
    logic [ACC_WIDTH-1:0]         result;
    logic                         mem_we;
    logic [AW-1:0]                mem_waddr;
    logic [ACC_WIDTH-1:0]         mem_wdata;

    always_comb begin
        data_ext = ACC_WIDTH'(s2_data_q);
        sum_wide = SUM_WIDTH'(s2_old_q) + SUM_WIDTH'(data_ext);
        sum_ovf  = add_overflow(sum_wide[SUM_WIDTH-1 -: 2]);
        if (s2_mode) begin
            result = data_ext;
        end else if (sum_ovf && SATURATE) begin
            result = sum_wide[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            result = sum_wide[ACC_WIDTH-1:0];
        end
    end

    // Stage 1 takes the stage-2 result instead of memory when both target the same row.
    always_comb begin
        s1_data_d = s1_load ? wr_data_col : s1_data_q;
        s2_data_d = s2_load ? s1_data_q : s2_data_q;
        s2_old_d  = s2_old_q;
        if (s2_load) begin
            s2_old_d = fwd_hit ? result : mem_q[s1_addr];
        end
        mem_we    = sweep_we | s2_commit;
        mem_waddr = sweep_we ? sweep_row : s2_addr;
        mem_wdata = sweep_we ? '0 : result;
        rd_data_d = rd_accept ? mem_q[rd_addr] : rd_data_q;
        ovf_d     = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (s2_commit && !s2_mode && sum_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s2_data_q <= '0;
            s2_old_q  <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            s2_old_q  <= s2_old_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data_col = rd_data_q;
    assign ovf         = ovf_q;

endmodule

// File: rtl/accum_bank.sv
// Banked per-column accumulator: zeroing sweep FSM, shared 2-stage
// read-modify-write pipeline control and 1-cycle read port.
module accum_bank
    import accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH    = 16,
    parameter int unsigned NUM_COLS     = 16,
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_COLS = 16,
    parameter bit          SATURATE     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    accum_bank_if.slave bus
);
    localparam int unsigned DEPTH = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int unsigned AW    = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic          s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic          s2_valid_q, s2_valid_d, s2_mode_q, s2_mode_d;
    logic [AW-1:0] s2_addr_q, s2_addr_d;
    logic          rd_valid_q, rd_valid_d;

    logic busy, sweep_we;
    logic clear_accept, wr_accept, rd_accept, s2_commit, fwd_hit;
    logic [NUM_COLS*ACC_WIDTH-1:0] rd_data_w;
    logic [NUM_COLS-1:0]           ovf_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d = SWEEP;
                    row_d   = '0;
                end
            end
            SWEEP: begin
                if (row_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    always_comb begin
        busy     = (state_q == SWEEP);
        sweep_we = (state_q == SWEEP);
    end

    // Clear flushes both stages, so an in-flight commit never lands after the sweep starts.
    always_comb begin
        clear_accept = !busy && bus.clear;
        wr_accept    = !busy && !bus.clear && bus.wr_en;
        rd_accept    = !busy && bus.rd_en;
        s2_commit    = s2_valid_q && !clear_accept;
        fwd_hit      = s1_valid_q && s2_valid_q && (s1_addr_q == s2_addr_q);
        s1_valid_d   = wr_accept;
        s1_addr_d    = wr_accept ? bus.wr_addr : s1_addr_q;
        s1_mode_d    = wr_accept ? bus.wr_mode : s1_mode_q;
        s2_valid_d   = s1_valid_q && !clear_accept;
        s2_addr_d    = s1_valid_q ? s1_addr_q : s2_addr_q;
        s2_mode_d    = s1_valid_q ? s1_mode_q : s2_mode_q;
        rd_valid_d   = rd_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_mode_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_mode_q  <= s2_mode_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        accum_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .DEPTH      (DEPTH),
            .AW         (AW),
            .SATURATE   (SATURATE)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .s1_load     (wr_accept),
            .wr_data_col (bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .s1_addr     (s1_addr_q),
            .s2_load     (s1_valid_q),
            .fwd_hit     (fwd_hit),
            .s2_mode     (s2_mode_q),
            .s2_commit   (s2_commit),
            .s2_addr     (s2_addr_q),
            .sweep_we    (sweep_we),
            .sweep_row   (row_q),
            .rd_accept   (rd_accept),
            .rd_addr     (bus.rd_addr),
            .ovf_clr     (clear_accept),
            .rd_data_col (rd_data_w[c*ACC_WIDTH +: ACC_WIDTH]),
            .ovf         (ovf_w[c])
        );
    end

    assign bus.busy     = busy;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_w;
    assign bus.ovf      = ovf_w;

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: a saturating and a wrapping instance share
// one stimulus stream; expected values are hand-computed constants.
module tb_accum_bank;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACW   = 16;
    localparam int unsigned NC    = 16;
    localparam int unsigned AW    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   rvbad;
    int   rows [7] = '{0, 2, 5, 7, 9, 11, 1023};

    always #5 clk = ~clk;

    accum_bank_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .NUM_COLS(NC), .AW(AW)) bus ();
    accum_bank_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .NUM_COLS(NC), .AW(AW)) bus_w ();

    accum_bank #(
        .DATA_WIDTH(DW), .ACC_WIDTH(ACW), .NUM_COLS(NC),
        .MAX_OUT_ROWS(128), .MAX_OUT_COLS(128), .SYS_ARR_COLS(16), .SATURATE(1'b1)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    accum_bank #(
        .DATA_WIDTH(DW), .ACC_WIDTH(ACW), .NUM_COLS(NC),
        .MAX_OUT_ROWS(128), .MAX_OUT_COLS(128), .SYS_ARR_COLS(16), .SATURATE(1'b0)
    ) u_dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w.slave));

    assign bus_w.clear   = bus.clear;
    assign bus_w.wr_en   = bus.wr_en;
    assign bus_w.wr_mode = bus.wr_mode;
    assign bus_w.wr_addr = bus.wr_addr;
    assign bus_w.wr_data = bus.wr_data;
    assign bus_w.rd_en   = bus.rd_en;
    assign bus_w.rd_addr = bus.rd_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*DW-1:0] wd(input int unsigned c, input logic [7:0] v);
        logic [NC*DW-1:0] r;
        r = '0;
        r[c*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [NC*ACW-1:0] rv(input int unsigned c, input logic [15:0] v);
        logic [NC*ACW-1:0] r;
        r = '0;
        r[c*ACW +: ACW] = v;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_mode = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;

        // Reset state
        repeat (3) step();
        chk("rst_busy", 256'(bus.busy), 256'(1));
        chk("rst_rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("rst_rd_data", 256'(bus.rd_data), 256'(0));
        chk("rst_ovf", 256'(bus.ovf), 256'(0));

        // Reset in the middle of a sweep restarts it from row 0
        rst_n = 1'b1;
        repeat (100) step();
        chk("midsweep_busy", 256'(bus.busy), 256'(1));
        rst_n = 1'b0;
        step();
        chk("midrst_busy", 256'(bus.busy), 256'(1));
        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 3000) begin
            step();
            n++;
        end
        chk("reset_sweep_len", 256'(n), 256'(1024));

        // Read row 5 after sweep
        bus.rd_en = 1'b1; bus.rd_addr = 10'd5;
        step();
        bus.rd_en = 1'b0;
        chk("rd5_valid", 256'(bus.rd_valid), 256'(1));
        chk("rd5_data", 256'(bus.rd_data), 256'(0));
        step();
        chk("rd_valid_pulse", 256'(bus.rd_valid), 256'(0));

        // Four back-to-back +3 accumulates to row 7
        bus.wr_en = 1'b1; bus.wr_mode = 1'b0; bus.wr_addr = 10'd7; bus.wr_data = wd(0, 8'd3);
        repeat (4) step();
        bus.wr_en = 1'b0;
        repeat (2) step();
        bus.rd_en = 1'b1; bus.rd_addr = 10'd7;
        step();
        bus.rd_en = 1'b0;
        chk("fwd_row7", 256'(bus.rd_data), 256'(rv(0, 16'd12)));

        // Overwrite 2 then accumulate -5 into row 9 col 3
        bus.wr_en = 1'b1; bus.wr_mode = 1'b1; bus.wr_addr = 10'd9; bus.wr_data = wd(3, 8'd2);
        step();
        bus.wr_mode = 1'b0; bus.wr_data = wd(3, 8'hFB);
        step();
        bus.wr_en = 1'b0;
        repeat (2) step();
        bus.rd_en = 1'b1; bus.rd_addr = 10'd9;
        step();
        bus.rd_en = 1'b0;
        chk("signext_row9", 256'(bus.rd_data), 256'(rv(3, 16'hFFFD)));

        // Read on the commit edge sees the old value
        bus.wr_en = 1'b1; bus.wr_mode = 1'b1; bus.wr_addr = 10'd11; bus.wr_data = wd(0, 8'd10);
        step();
        bus.wr_en = 1'b0;
        repeat (2) step();
        bus.wr_en = 1'b1; bus.wr_mode = 1'b0; bus.wr_data = wd(0, 8'd7);
        step();
        bus.wr_en = 1'b0;
        step();
        bus.rd_en = 1'b1; bus.rd_addr = 10'd11;
        step();
        chk("rd_commit_edge_old", 256'(bus.rd_data), 256'(rv(0, 16'd10)));
        step();
        bus.rd_en = 1'b0;
        chk("rd_after_commit_new", 256'(bus.rd_data), 256'(rv(0, 16'd17)));
        step();
        chk("rd_hold_valid", 256'(bus.rd_valid), 256'(0));
        chk("rd_hold_data", 256'(bus.rd_data), 256'(rv(0, 16'd17)));

        // Row 2: build 32760 in col 0 and -32768 in col 2, then overflow both
        bus.wr_en = 1'b1; bus.wr_mode = 1'b1; bus.wr_addr = 10'd2;
        bus.wr_data = wd(0, 8'h7F) | wd(2, 8'h80);
        step();
        bus.wr_mode = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.wr_data = wd(0, 8'h7F) | ((i < 255) ? wd(2, 8'h80) : '0);
            step();
        end
        bus.wr_data = wd(0, 8'h79);
        step();
        bus.wr_en = 1'b0;
        repeat (2) step();
        bus.rd_en = 1'b1; bus.rd_addr = 10'd2;
        step();
        bus.rd_en = 1'b0;
        chk("pre_ovf_sat", 256'(bus.rd_data), 256'(rv(0, 16'h7FF8) | rv(2, 16'h8000)));
        chk("pre_ovf_wrap", 256'(bus_w.rd_data), 256'(rv(0, 16'h7FF8) | rv(2, 16'h8000)));
        chk("pre_ovf_flag_sat", 256'(bus.ovf), 256'(0));
        chk("pre_ovf_flag_wrap", 256'(bus_w.ovf), 256'(0));
        bus.wr_en = 1'b1; bus.wr_data = wd(0, 8'h7F) | wd(2, 8'h80);
        step();
        bus.wr_en = 1'b0;
        repeat (2) step();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("sat_row2", 256'(bus.rd_data), 256'(rv(0, 16'h7FFF) | rv(2, 16'h8000)));
        chk("sat_ovf", 256'(bus.ovf), 256'(16'h0005));
        chk("wrap_row2", 256'(bus_w.rd_data), 256'(rv(0, 16'h8077) | rv(2, 16'h7F80)));
        chk("wrap_ovf", 256'(bus_w.ovf), 256'(16'h0005));

        // Clear mid-stream with an overflowing write in stage 2
        bus.wr_en = 1'b1; bus.wr_mode = 1'b0; bus.wr_addr = 10'd2; bus.wr_data = wd(0, 8'h7F);
        repeat (2) step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clear_busy", 256'(bus.busy), 256'(1));
        chk("clear_ovf_sat", 256'(bus.ovf), 256'(0));
        chk("clear_ovf_wrap", 256'(bus_w.ovf), 256'(0));
        n = 0;
        rvbad = 0;
        while (bus.busy && n < 3000) begin
            bus.clear = (n == 10);
            bus.wr_en = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = wd(0, 8'd1);
            bus.rd_en = 1'b1; bus.rd_addr = 10'd7;
            step();
            n++;
            if (bus.rd_valid !== 1'b0) rvbad++;
        end
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("clear_sweep_len", 256'(n), 256'(1024));
        chk("sweep_rd_quiet", 256'(rvbad), 256'(0));
        chk("post_sweep_ovf", 256'(bus.ovf), 256'(0));
        for (int i = 0; i < 7; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = rows[i][AW-1:0];
            step();
            chk($sformatf("zero_row%0d_sat", rows[i]), 256'(bus.rd_data), 256'(0));
            chk($sformatf("zero_row%0d_wrap", rows[i]), 256'(bus_w.rd_data), 256'(0));
        end
        chk("zero_rd_valid", 256'(bus.rd_valid), 256'(1));
        bus.rd_en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
